spi_master: RTL and testbench

- SPI mode-0 master (CPOL=0, CPHA=0), 8-bit frames, MSB first. It is the initiator end of the link served by the team's spi_slaver.
- It drives cs/sck/MOSI and samples MISO. Bytes arrive on a valid/ready stream, and each received byte is returned with a one-cycle flag.
- Multi-byte transfers keep cs low between bytes. Used on-chip for bring-up loopback against spi_slaver and to drive external SPI peripherals (DDS/DAC config).

---
 rtl/spi_master.sv | 205 ++++++++++++++++++++
 tb/tb_spi_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: 8-bit MSB-first frames with a valid/ready byte stream in and a flagged byte out.
// Every output is taken directly from a flop; cs stays low across back-to-back bytes of one frame.
module spi_master #(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_IDLE  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txd_data,
  input  logic       txd_last,
  input  logic       txd_valid,
  output logic       txd_ready,
  output logic [7:0] rxd_out,
  output logic       rxd_flag,
  output logic       busy,
  output logic       cs,
  output logic       sck,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT    = 3'd2,
    BYTE_END = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } state_e;

  localparam logic [7:0] DIV_END   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_END = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_END  = 8'(CS_HOLD - 1);
  localparam logic [7:0] IDLE_END  = 8'(CS_IDLE - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic       half_q, half_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic       last_q, last_d;
  logic       miso_s1_q, miso_s2_q;
  logic       cs_q, cs_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       txd_ready_q, txd_ready_d;
  logic       rxd_flag_q, rxd_flag_d;
  logic [7:0] rxd_q, rxd_d;
  logic       busy_q, busy_d;
  logic       accept_s;

  assign accept_s = txd_valid & txd_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 3'd0;
      half_q      <= 1'b0;
      tx_sr_q     <= 8'd0;
      rx_sr_q     <= 8'd0;
      last_q      <= 1'b0;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
      cs_q        <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      txd_ready_q <= 1'b0;
      rxd_flag_q  <= 1'b0;
      rxd_q       <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      half_q      <= half_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      last_q      <= last_d;
      miso_s1_q   <= MISO;
      miso_s2_q   <= miso_s1_q;
      cs_q        <= cs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      txd_ready_q <= txd_ready_d;
      rxd_flag_q  <= rxd_flag_d;
      rxd_q       <= rxd_d;
      busy_q      <= busy_d;
    end
  end

  // half_q selects the sck-low (0) or sck-high (1) half of the current bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    half_d  = half_q;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SETUP;
          cnt_d   = 8'd0;
          tx_sr_d = txd_data;
          last_d  = txd_last;
        end else begin
          cnt_d = 8'd0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_END) begin
          state_d = SHIFT;
          cnt_d   = 8'd0;
          bit_d   = 3'd7;
          half_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != DIV_END) begin
          cnt_d = cnt_q + 8'd1;
        end else if (!half_q) begin
          cnt_d  = 8'd0;
          half_d = 1'b1;
        end else begin
          cnt_d   = 8'd0;
          half_d  = 1'b0;
          rx_sr_d = {rx_sr_q[6:0], miso_s2_q};
          if (bit_q == 3'd0) begin
            state_d = BYTE_END;
          end else begin
            bit_d   = bit_q - 3'd1;
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end
      end
      BYTE_END: begin
        cnt_d = 8'd0;
        if (accept_s) begin
          state_d = SHIFT;
          bit_d   = 3'd7;
          half_d  = 1'b0;
          tx_sr_d = txd_data;
          last_d  = txd_last;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_END) begin
          state_d = GAP;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == IDLE_END) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered without lag
  always_comb begin
    cs_d        = (state_d == IDLE) || (state_d == GAP);
    sck_d       = (state_d == SHIFT) && half_d;
    busy_d      = (state_d != IDLE);
    txd_ready_d = (state_d == IDLE) || ((state_d == BYTE_END) && !last_d);
    rxd_flag_d  = (state_d == BYTE_END);
    if (state_d == BYTE_END) begin
      rxd_d = rx_sr_d;
    end else begin
      rxd_d = rxd_q;
    end
    if ((state_d == SETUP) || (state_d == SHIFT)) begin
      mosi_d = tx_sr_d[7];
    end else begin
      mosi_d = mosi_q;
    end
  end

  assign cs        = cs_q;
  assign sck       = sck_q;
  assign MOSI      = mosi_q;
  assign txd_ready = txd_ready_q;
  assign rxd_flag  = rxd_flag_q;
  assign rxd_out   = rxd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=4 instance driven through single, streamed, loopback,
// underrun and reset cases, plus a minimum-timing CLK_DIV=3 instance for the MISO capture edge.
module tb_spi_master;

  localparam int DIV0 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] txd_data = 8'h00;
  logic       txd_last = 1'b0;
  logic       txd_valid = 1'b0;
  logic       txd_ready, rxd_flag, busy, cs, sck, mosi;
  logic [7:0] rxd_out;
  logic [7:0] txd_data3 = 8'h00;
  logic       txd_last3 = 1'b0;
  logic       txd_valid3 = 1'b0;
  logic       txd_ready3, rxd_flag3, busy3, cs3, sck3, mosi3;
  logic [7:0] rxd_out3;
  logic [1:0] miso_v = 2'b00;

  int total = 0;
  int bad = 0;

  spi_master #(.CLK_DIV(DIV0), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(3)) dut (
    .clk(clk), .rst(rst), .txd_data(txd_data), .txd_last(txd_last), .txd_valid(txd_valid),
    .txd_ready(txd_ready), .rxd_out(rxd_out), .rxd_flag(rxd_flag), .busy(busy),
    .cs(cs), .sck(sck), .MOSI(mosi), .MISO(miso_v[0])
  );

  spi_master #(.CLK_DIV(3), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut3 (
    .clk(clk), .rst(rst), .txd_data(txd_data3), .txd_last(txd_last3), .txd_valid(txd_valid3),
    .txd_ready(txd_ready3), .rxd_out(rxd_out3), .rxd_flag(rxd_flag3), .busy(busy3),
    .cs(cs3), .sck(sck3), .MOSI(mosi3), .MISO(miso_v[1])
  );

  always #5 clk = ~clk;

  // Slave models: present bit7 at cs fall, next bit one clk after each sck fall, capture MOSI on rise
  logic       lb_mode = 1'b0;
  logic [7:0] sl_tx0 = 8'h3C;
  logic [1:0] s_cs, s_sck, s_mosi;
  logic [1:0] sp_cs = 2'b11;
  logic [1:0] sp_sck = 2'b00;
  logic [7:0] s_sr [2];
  logic [7:0] s_rx [2];
  logic [3:0] s_cnt [2];
  assign s_cs = {cs3, cs};
  assign s_sck = {sck3, sck};
  assign s_mosi = {mosi3, mosi};

  function automatic logic [7:0] next_tx(input int k, input logic [7:0] rx);
    if (k == 0) return lb_mode ? rx + 8'd1 : sl_tx0;
    return 8'h5A;
  endfunction

  function automatic logic msb(input logic [7:0] v);
    return v[7];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sp_cs[k] <= s_cs[k];
      sp_sck[k] <= s_sck[k];
      if (sp_cs[k] && !s_cs[k]) begin
        s_sr[k] <= next_tx(k, s_rx[k]);
        miso_v[k] <= msb(next_tx(k, s_rx[k]));
        s_cnt[k] <= 4'd0;
      end else if (!s_cs[k]) begin
        if (!sp_sck[k] && s_sck[k]) begin
          s_rx[k] <= {s_rx[k][6:0], s_mosi[k]};
          s_cnt[k] <= s_cnt[k] + 4'd1;
        end else if (sp_sck[k] && !s_sck[k]) begin
          if (s_cnt[k] == 4'd8) begin
            s_sr[k] <= next_tx(k, s_rx[k]);
            miso_v[k] <= msb(next_tx(k, s_rx[k]));
            s_cnt[k] <= 4'd0;
          end else begin
            s_sr[k] <= s_sr[k] << 1;
            miso_v[k] <= s_sr[k][6];
          end
        end
      end
    end
  end

  // Free-running event counters on the CLK_DIV=4 instance; the sequence compares deltas
  int rises = 0, flags = 0, flags3 = 0, cs_rises = 0, cs_len = 0, last_cs_low = 0;
  int gap_len = 0, last_gap = 0, rdy_in = 0, low_run = 0, gap5 = 0;
  logic prev_sck = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0, seen = 1'b0;

  always @(negedge clk) begin
    prev_sck <= sck;
    prev_cs <= cs;
    prev_busy <= busy;
    flags <= flags + int'(rxd_flag);
    flags3 <= flags3 + int'(rxd_flag3);
    if (sck && !prev_sck) rises <= rises + 1;
    if (!cs) cs_len <= cs_len + 1;
    else cs_len <= 0;
    if (cs && !prev_cs) begin
      cs_rises <= cs_rises + 1;
      last_cs_low <= cs_len;
    end
    if (cs && busy) gap_len <= gap_len + 1;
    else gap_len <= 0;
    if (!busy && prev_busy) last_gap <= gap_len;
    if (txd_ready && !cs) rdy_in <= rdy_in + 1;
    if (cs) begin
      low_run <= 0;
      seen <= 1'b0;
    end else if (!sck) begin
      low_run <= low_run + 1;
    end else if (!prev_sck) begin
      seen <= 1'b1;
      low_run <= 0;
      if (seen && low_run == DIV0 + 1) gap5 <= gap5 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    total++;
    bad++;
    $error("FAIL %s timeout", tag);
  endtask

  task automatic push0(input logic [7:0] d, input logic l);
    int n = 0;
    txd_data = d;
    txd_last = l;
    txd_valid = 1'b1;
    while (!txd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) tmo("push0");
    @(negedge clk);
    txd_valid = 1'b0;
  endtask

  task automatic wait_idle0();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) tmo("idle0");
    @(negedge clk);
    @(negedge clk);
  endtask

  int r0, f0, c0, g0, q0, n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ready", 32'(txd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flag", 32'(rxd_flag), 32'd0);
    check("rst_rxd", 32'(rxd_out), 32'h00);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(txd_ready), 32'd1);

    // single byte A5, slave returns 3C
    r0 = rises; f0 = flags;
    push0(8'hA5, 1'b1);
    wait_idle0();
    check("t1_rises", 32'(rises - r0), 32'd8);
    check("t1_mosi_bits", 32'(s_rx[0]), 32'hA5);
    check("t1_flags", 32'(flags - f0), 32'd1);
    check("t1_rxd", 32'(rxd_out), 32'h3C);
    check("t1_cs_low", 32'(last_cs_low), 32'd69);
    check("t1_busy_gap", 32'(last_gap), 32'd3);

    // three-byte stream, valid held high
    r0 = rises; f0 = flags; c0 = cs_rises; g0 = gap5; q0 = rdy_in;
    push0(8'h01, 1'b0);
    push0(8'h80, 1'b0);
    push0(8'hFF, 1'b1);
    wait_idle0();
    check("t2_cs_one_frame", 32'(cs_rises - c0), 32'd1);
    check("t2_flags", 32'(flags - f0), 32'd3);
    check("t2_rises", 32'(rises - r0), 32'd24);
    check("t2_ready_in_frame", 32'(rdy_in - q0), 32'd2);
    check("t2_interbyte_gap", 32'(gap5 - g0), 32'd2);
    check("t2_last_mosi", 32'(s_rx[0]), 32'hFF);
    check("t2_cs_low", 32'(last_cs_low), 32'd69 + 32'd2 * 32'd65);

    // loopback: slave echoes previous byte + 1
    lb_mode = 1'b1;
    push0(8'h10, 1'b0);
    push0(8'h20, 1'b1);
    wait_idle0();
    check("t3_loopback_rxd", 32'(rxd_out), 32'h11);
    check("t3_slave_rx", 32'(s_rx[0]), 32'h20);
    lb_mode = 1'b0;

    // underrun after a non-last byte, then a byte offered during the gap
    f0 = flags; r0 = rises;
    push0(8'h77, 1'b0);
    n = 0;
    while (!cs && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) tmo("t4_cs_rise");
    txd_data = 8'h33; txd_last = 1'b1; txd_valid = 1'b1;
    n = 0;
    while (!txd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_gap_before_ready", 32'(n), 32'd3);
    @(negedge clk);
    txd_valid = 1'b0;
    wait_idle0();
    check("t4_flags", 32'(flags - f0), 32'd2);
    check("t4_rises", 32'(rises - r0), 32'd16);
    check("t4_cs_low", 32'(last_cs_low), 32'd69);
    check("t4_second_frame", 32'(s_rx[0]), 32'h33);

    // reset after three sck rises
    r0 = rises; f0 = flags;
    push0(8'hC3, 1'b1);
    n = 0;
    while ((rises - r0) < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) tmo("t5_rises");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_cs", 32'(cs), 32'd1);
    check("t5_sck", 32'(sck), 32'd0);
    check("t5_rxd", 32'(rxd_out), 32'h00);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("t5_no_flag", 32'(flags - f0), 32'd0);
    push0(8'h96, 1'b1);
    wait_idle0();
    check("t5_after_rxd", 32'(rxd_out), 32'h3C);
    check("t5_after_mosi", 32'(s_rx[0]), 32'h96);

    // CLK_DIV=3 instance, slave drives 5A
    f0 = flags3;
    txd_data3 = 8'hE1; txd_last3 = 1'b1; txd_valid3 = 1'b1;
    n = 0;
    while (!txd_ready3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) tmo("t6_ready");
    @(negedge clk);
    txd_valid3 = 1'b0;
    n = 0;
    while (busy3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) tmo("t6_idle");
    @(negedge clk);
    check("t6_rxd", 32'(rxd_out3), 32'h5A);
    check("t6_mosi", 32'(s_rx[1]), 32'hE1);
    check("t6_flags", 32'(flags3 - f0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
